// File: rtl/window_streamer_3x3.sv
// ---------------------------------------------------------------------------
// window_streamer_3x3
//
// Takes a raster-order pixel stream and emits every fully-inside 3x3
// neighbourhood (stride 1, no padding) as one packed word, together with the
// window's top-left coordinate. Two line buffers hold the previous two image
// rows. A two-column history register plus the incoming column forms the
// 3x3 window. The block re-arms for the next frame after the last pixel.
//
// Ports
//   clk, rst     clock; asynchronous active-high reset
//   in_pixel     pixel data, row-major order
//   in_valid     in_pixel valid
//   in_ready     block can accept a pixel this cycle
//   win_data     window, element k = 3*i+j (i = row from top, j = col from
//                left) at bits [k*DATA_W +: DATA_W]
//   win_valid    win_data / win_row / win_col valid
//   win_ready    downstream accepts the window
//   win_row      top-left row of the window, 0..IMG_H-3
//   win_col      top-left column of the window, 0..IMG_W-3
//   frame_done   one-cycle pulse after the frame's last window is consumed
//
// Handshakes: a pixel moves on a cycle with in_valid && in_ready. A window
// moves on a cycle with win_valid && win_ready. There is a single output
// register and no skid buffer, so in_ready = !win_valid || win_ready. While a
// window is stalled, the output register and the input are both frozen.
// ---------------------------------------------------------------------------
module window_streamer_3x3 #(
   parameter int IMG_H  = 28,
   parameter int IMG_W  = 28,
   parameter int DATA_W = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [DATA_W-1:0]          in_pixel,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [9*DATA_W-1:0]        win_data,
   output logic                       win_valid,
   input  logic                       win_ready,
   output logic [$clog2(IMG_H)-1:0]   win_row,
   output logic [$clog2(IMG_W)-1:0]   win_col,
   output logic                       frame_done
);

   localparam int RW = $clog2(IMG_H);
   localparam int CW = $clog2(IMG_W);

   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] WROW_END = RW'(IMG_H - 3);
   localparam logic [CW-1:0] WCOL_END = CW'(IMG_W - 3);

   // line0 holds the row above the current one, line1 the row above that.
   // Neither is cleared by reset: rows 0/1 of every frame rewrite them before
   // any window can read them.
   logic [DATA_W-1:0] line0_q [IMG_W];
   logic [DATA_W-1:0] line1_q [IMG_W];

   // Two previous window columns, [row][0 = older, 1 = newer].
   logic [DATA_W-1:0] hist_q [3][2];
   logic [DATA_W-1:0] new_col [3];

   logic [CW-1:0]       col_q, col_d;
   logic [RW-1:0]       row_q, row_d;
   logic                win_valid_q, win_valid_d;
   logic [9*DATA_W-1:0] win_data_q, win_data_d;
   logic [RW-1:0]       win_row_q, win_row_d;
   logic [CW-1:0]       win_col_q, win_col_d;
   logic                frame_done_q, frame_done_d;

   logic accept;
   logic consume;
   logic emit;

   assign in_ready = !win_valid_q || win_ready;
   assign accept   = in_valid && in_ready;
   assign consume  = win_valid_q && win_ready;
   assign emit     = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));

   // Incoming right-hand column, top to bottom.
   assign new_col[0] = line1_q[col_q];
   assign new_col[1] = line0_q[col_q];
   assign new_col[2] = in_pixel;

   // Raster position of the next pixel to be accepted.
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (accept) begin
         if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end
   end

   // Output register. A load wins over a consume in the same cycle, so
   // back-to-back windows keep win_valid high.
   always_comb begin
      win_valid_d  = win_valid_q;
      win_data_d   = win_data_q;
      win_row_d    = win_row_q;
      win_col_d    = win_col_q;
      frame_done_d = consume && (win_row_q == WROW_END) && (win_col_q == WCOL_END);
      if (emit) begin
         win_valid_d = 1'b1;
         win_row_d   = row_q - RW'(2);
         win_col_d   = col_q - CW'(2);
         for (int i = 0; i < 3; i++) begin
            win_data_d[(3*i + 0)*DATA_W +: DATA_W] = hist_q[i][0];
            win_data_d[(3*i + 1)*DATA_W +: DATA_W] = hist_q[i][1];
            win_data_d[(3*i + 2)*DATA_W +: DATA_W] = new_col[i];
         end
      end else if (consume) begin
         win_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q        <= '0;
         row_q        <= '0;
         win_valid_q  <= 1'b0;
         win_data_q   <= '0;
         win_row_q    <= '0;
         win_col_q    <= '0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         win_valid_q  <= win_valid_d;
         win_data_q   <= win_data_d;
         win_row_q    <= win_row_d;
         win_col_q    <= win_col_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Pixel storage: no reset needed, contents are only trusted once rewritten.
   always_ff @(posedge clk) begin
      if (accept) begin
         line1_q[col_q] <= line0_q[col_q];
         line0_q[col_q] <= in_pixel;
         for (int i = 0; i < 3; i++) begin
            hist_q[i][0] <= hist_q[i][1];
            hist_q[i][1] <= new_col[i];
         end
      end
   end

   assign win_valid  = win_valid_q;
   assign win_data   = win_data_q;
   assign win_row    = win_row_q;
   assign win_col    = win_col_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_window_streamer_3x3.sv
// ---------------------------------------------------------------------------
// tb_window_streamer_3x3
//
// Bench for window_streamer_3x3 at the default 28x28x8 geometry. A driver
// streams whole images (ramp, inverted ramp, random). On every accepted
// pixel that completes a window, it pushes the window expected from the
// stored image onto exp_q. A monitor pops exp_q on each window handshake and
// also times frame_done. A table of hand-computed windows is checked against
// the captured output.
// ---------------------------------------------------------------------------
module tb_window_streamer_3x3;

   localparam int H  = 28;
   localparam int W  = 28;
   localparam int DW = 8;
   localparam int RW = 5;
   localparam int CW = 5;
   localparam int EW = RW + CW + 9*DW;

   logic              clk = 1'b0;
   logic              rst;
   logic [DW-1:0]     in_pixel;
   logic              in_valid;
   logic              in_ready;
   logic [9*DW-1:0]   win_data;
   logic              win_valid;
   logic              win_ready;
   logic [RW-1:0]     win_row;
   logic [CW-1:0]     win_col;
   logic              frame_done;

   window_streamer_3x3 #(.IMG_H(H), .IMG_W(W), .DATA_W(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_pixel   (in_pixel),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .win_data   (win_data),
      .win_valid  (win_valid),
      .win_ready  (win_ready),
      .win_row    (win_row),
      .win_col    (win_col),
      .frame_done (frame_done)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int              checks = 0;
   int              errors = 0;
   logic [EW-1:0]   exp_q[$];
   logic [EW-1:0]   mon_e;
   logic [DW-1:0]   img [H][W];
   logic [9*DW-1:0] cap [2][H-2][W-2];
   int              cap_sel  = 0;
   int              win_cnt  = 0;
   int              done_cnt = 0;
   bit              done_due = 1'b0;

   typedef struct packed {
      logic [0:0]  sel;
      logic [4:0]  r;
      logic [4:0]  c;
      logic [71:0] exp;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [71:0] pack9(input int e0, input int e1, input int e2,
                                         input int e3, input int e4, input int e5,
                                         input int e6, input int e7, input int e8);
      return {8'(e8), 8'(e7), 8'(e6), 8'(e5), 8'(e4), 8'(e3), 8'(e2), 8'(e1), 8'(e0)};
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (rst) begin
         done_due = 1'b0;
      end else begin
         if (frame_done || done_due) check("frame_done", frame_done, done_due);
         if (frame_done) done_cnt++;
         done_due = 1'b0;
         if (win_valid && win_ready) begin
            win_cnt++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL win_extra actual row=%0d col=%0d required no window", win_row, win_col);
            end else begin
               mon_e = exp_q.pop_front();
               check("window", {win_row, win_col, win_data}, mon_e);
            end
            if (win_row < RW'(H-2) && win_col < CW'(W-2))
               cap[cap_sel][win_row][win_col] = win_data;
            if (win_row == RW'(H-3) && win_col == CW'(W-3)) begin
               done_due = 1'b1;
               cap_sel  = (cap_sel + 1) % 2;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic hold_check(input logic [DW-1:0] nxt);
      logic [EW-1:0] snap;
      @(posedge clk); #1;
      win_ready = 1'b0;
      in_valid  = 1'b1;
      in_pixel  = nxt;
      check("hold_valid", win_valid, 1);
      snap = {win_row, win_col, win_data};
      repeat (10) begin
         @(negedge clk);
         check("hold_in_ready", in_ready, 0);
         check("hold_stable", {win_row, win_col, win_data}, snap);
      end
   endtask

   // mode 0 ramp, 1 inverted ramp, 2 random
   task automatic run_frame(input int mode, input int pv, input int pr, input int n_pix,
                            input int hold_idx, input bit lat_chk);
      bit lat_pend = 1'b0;
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            case (mode)
               0:       img[r][c] = 8'((r*W + c) % 256);
               1:       img[r][c] = 8'(255 - ((r*W + c) % 256));
               default: img[r][c] = 8'($urandom_range(0, 255));
            endcase
      for (int idx = 0; idx < n_pix; idx++) begin
         int r;
         int c;
         int waited;
         bit acc;
         logic [71:0] d;
         r = idx / W;
         c = idx % W;
         waited = 0;
         acc = 1'b0;
         while (!acc) begin
            @(posedge clk); #1;
            if (lat_pend) begin
               check("lat_valid", win_valid, 1);
               check("lat_row", win_row, 0);
               check("lat_col", win_col, 0);
               lat_pend = 1'b0;
            end
            in_valid  = ($urandom_range(1, 100) <= pv);
            in_pixel  = in_valid ? img[r][c] : 8'($urandom_range(0, 255));
            win_ready = ($urandom_range(1, 100) <= pr);
            @(negedge clk);
            acc = in_valid && in_ready;
            waited++;
            if (!acc && waited > 1000) begin
               checks++;
               errors++;
               $display("FAIL in_timeout actual=no accept of pixel %0d required=accept", idx);
               in_valid = 1'b0;
               return;
            end
         end
         if (r >= 2 && c >= 2) begin
            for (int i = 0; i < 3; i++)
               for (int j = 0; j < 3; j++)
                  d[(3*i + j)*DW +: DW] = img[r-2+i][c-2+j];
            exp_q.push_back({5'(r-2), 5'(c-2), d});
         end
         if (lat_chk && r == 2 && c == 2) begin
            check("first_win_early", win_valid, 0);
            lat_pend = 1'b1;
         end
         if (idx == hold_idx) hold_check(img[(idx+1)/W][(idx+1)%W]);
      end
   endtask

   task automatic drain();
      int n = 0;
      @(posedge clk); #1;
      in_valid  = 1'b0;
      win_ready = 1'b1;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
         exp_q.delete();
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst       = 1'b1;
      in_valid  = 1'b0;
      win_ready = 1'b0;
      exp_q.delete();
      #1;
      check("rst_win_valid", win_valid, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_win_row", win_row, 0);
      check("rst_win_col", win_col, 0);
      check("rst_win_data", win_data, 0);
      check("rst_in_ready", in_ready, 1);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", in_ready, 1);
      check("post_rst_win_valid", win_valid, 0);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_pixel  = '0;
      win_ready = 1'b0;

      vecs[0] = '{sel: 1'b0, r: 5'd0,  c: 5'd0,  exp: pack9(0, 1, 2, 28, 29, 30, 56, 57, 58)};
      vecs[1] = '{sel: 1'b0, r: 5'd0,  c: 5'd25, exp: pack9(25, 26, 27, 53, 54, 55, 81, 82, 83)};
      vecs[2] = '{sel: 1'b0, r: 5'd9,  c: 5'd2,  exp: pack9(254, 255, 0, 26, 27, 28, 54, 55, 56)};
      vecs[3] = '{sel: 1'b0, r: 5'd25, c: 5'd25, exp: pack9(213, 214, 215, 241, 242, 243, 13, 14, 15)};
      vecs[4] = '{sel: 1'b1, r: 5'd0,  c: 5'd0,  exp: pack9(255, 254, 253, 227, 226, 225, 199, 198, 197)};
      vecs[5] = '{sel: 1'b1, r: 5'd25, c: 5'd25, exp: pack9(42, 41, 40, 14, 13, 12, 242, 241, 240)};

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("init_in_ready", in_ready, 1);
      check("init_win_valid", win_valid, 0);

      // Full-rate ramp frame followed back to back by its inverse.
      cap_sel  = 0;
      win_cnt  = 0;
      done_cnt = 0;
      run_frame(0, 100, 100, H*W, -1, 1'b1);
      run_frame(1, 100, 100, H*W, -1, 1'b0);
      drain();
      check("ab_windows", win_cnt, 2*(H-2)*(W-2));
      check("ab_frame_done", done_cnt, 2);
      for (int i = 0; i < 6; i++)
         check($sformatf("table%0d", i), cap[vecs[i].sel][vecs[i].r][vecs[i].c], vecs[i].exp);

      // Ten-cycle output stall in the middle of a frame.
      win_cnt  = 0;
      done_cnt = 0;
      run_frame(0, 100, 100, H*W, 5*W + 7, 1'b0);
      drain();
      check("hold_windows", win_cnt, (H-2)*(W-2));
      check("hold_frame_done", done_cnt, 1);

      // Random input gaps and output stalls over three frames.
      win_cnt  = 0;
      done_cnt = 0;
      repeat (3) run_frame(2, 50, 70, H*W, -1, 1'b0);
      drain();
      check("rand_windows", win_cnt, 3*(H-2)*(W-2));
      check("rand_frame_done", done_cnt, 3);

      // Reset after 300 pixels, then one clean frame.
      run_frame(2, 80, 80, 300, -1, 1'b0);
      do_reset();
      cap_sel  = 0;
      win_cnt  = 0;
      done_cnt = 0;
      run_frame(0, 100, 100, H*W, -1, 1'b1);
      drain();
      check("rstf_windows", win_cnt, (H-2)*(W-2));
      check("rstf_frame_done", done_cnt, 1);
      check("rstf_first_win", cap[0][0][0], vecs[0].exp);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/window_streamer_3x3.md
Name: window_streamer_3x3

Overview:
- Receiving end of the raster pixel stream (valid/ready) feeding the CNN's first convolution layer.
- Consumes IMG_H x IMG_W pixels in row-major order and buffers two full lines internally.
- Emits every fully-inside 3x3 neighbourhood (no padding, stride 1) as one packed window over a second valid/ready interface, with window coordinates.
- Re-arms automatically for the next frame.

Parameters:
- IMG_H, 28, image height in pixels (>=3).
- IMG_W, 28, image width in pixels (>=3).
- DATA_W, 8, pixel width in bits.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_pixel  in  DATA_W  incoming pixel, raster order.
- in_valid  in  1  in_pixel valid.
- in_ready  out  1  block can accept a pixel this cycle.
- win_data  out  9*DATA_W  3x3 window; element k=3*i+j (i=row 0 top, j=col 0 left) at bits [k*DATA_W +: DATA_W].
- win_valid  out  1  win_data/win_row/win_col valid.
- win_ready  in  1  downstream accepts window.
- win_row  out  $clog2(IMG_H)  top-left row of window, 0..IMG_H-3.
- win_col  out  $clog2(IMG_W)  top-left col of window, 0..IMG_W-3.
- frame_done  out  1  one-cycle pulse, frame's last window consumed.

Behaviour:
- Reset (async): col/row counters=0; win_valid=0; win_data=0; win_row=0; win_col=0; frame_done=0. in_ready=1 immediately after reset. Line-buffer RAM not cleared; stale contents are never emitted.
- Handshakes:
  - Pixel accepted when in_valid&&in_ready.
  - Window consumed when win_valid&&win_ready.
  - in_ready = !win_valid || win_ready (combinational; single output register, no skid).
- Storage: two line buffers of IMG_W entries plus a 3x3 shift register.
- On each accepted pixel at (r,c):
  - Shift the window left by one column.
  - New right column = {line1[c], line0[c], in_pixel} (top to bottom).
  - line1[c] <= line0[c]; line0[c] <= in_pixel.
  - c increments; at IMG_W-1 it wraps to 0 and r increments; at (IMG_H-1, IMG_W-1) both wrap to 0.
- Window emission:
  - Accepting pixel (r,c) with r>=2 && c>=2 loads the output register next edge: win_valid=1, win_row=r-2, win_col=c-2.
  - Latency: 1 cycle from pixel accept to win_valid.
  - Windows per frame: (IMG_H-2)*(IMG_W-2) (676 at default).
- Output register rules:
  - Consumed with no new window loaded: win_valid -> 0.
  - Consumed and new window loaded in same cycle: win_valid stays 1 with new contents.
  - While win_valid=1 and win_ready=0: win_data, win_row, win_col held stable; in_ready=0.
- Pixels with c<2 or r<2 update buffers only; no window.
- frame_done:
  - 1 on the cycle after the handshake of window (IMG_H-3, IMG_W-3), for exactly one cycle.
  - Pixels of the next frame may be accepted before that handshake; row 0/1 of the new frame produce no windows, so there is no overlap.
- in_pixel ignored when in_valid=0. No back-pressure on in_valid; the upstream may drop valid at any time.
- Reset mid-frame: partial frame discarded; next accepted pixel is (0,0).

Test Plan:
- Reset: assert rst mid-stream -> win_valid=0, frame_done=0, win_row=win_col=0, in_ready=1 while rst high and after release.
- Full frame, win_ready=1, in_valid=1 every cycle, pixel=(r*28+c) mod 256:
  - First win_valid 1 cycle after accepting pixel (2,2), with win_row=0, win_col=0, elements 0..8 = 0,1,2,28,29,30,56,57,58.
  - 676 windows in raster order.
  - frame_done high exactly once, cycle after final window (25,25).
- Backpressure: hold win_ready=0 for 10 cycles while win_valid=1 -> in_ready=0, win_data/win_row/win_col unchanged. Release -> no pixel lost or duplicated; sequence matches golden model.
- Random stall: in_valid random 50% and win_ready random 30% low over 3 frames -> window sequence and coordinates identical to software 3x3 sliding-window model; frame_done count=3.
- Back-to-back frames, frame 2 pixels=255-frame1 -> frame 2 window (0,0) = 255,254,253,227,226,225,199,198,197; frame_done pulses twice.
- Reset after 300 accepted pixels, then a clean frame -> first window is (0,0) with correct data; exactly 676 windows follow.
